// File: rtl/charlieplex_scanner.sv
// Charlieplexed LED matrix scanner for the binary clock display.
// PINS tri-state pins address PINS*(PINS-1) pixels. Each row slot opens with
// BLANK cycles of all pins released, followed by DWELL cycles in which the row
// anode is driven high. The lit cathodes are pulled low for the first
// bright_act cycles of the dwell.
// Pixel data is double-buffered. Loads land in a pending buffer, and that
// buffer is promoted to the active buffer on the frame wrap edge.
module charlieplex_scanner #(
    parameter int PINS  = 6,
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int BW    = $clog2(DWELL + 1),
    parameter int RW    = ($clog2(PINS) > 1) ? $clog2(PINS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PINS*(PINS-1)-1:0] pixels,
    input  logic [BW-1:0]            brightness,
    input  logic                     load,
    output logic                     frame_ready,
    output logic [PINS-1:0]          pin_out,
    output logic [PINS-1:0]          pin_oe,
    output logic [RW-1:0]            row,
    output logic                     frame_start
);

    localparam int NPIX = PINS * (PINS - 1);
    localparam int S    = BLANK + DWELL;
    localparam int PW   = (S > 1) ? $clog2(S) : 1;

    // row_c/ph_c name the slot position that the next clock edge puts on the
    // pins. The outputs are registered, so they trail this position by one
    // cycle. As a result, the first edge after reset shows (0,0).
    logic [RW-1:0]   row_c, row_n;
    logic [PW-1:0]   ph_c, ph_n;
    logic            frame_edge;

    logic [NPIX-1:0] act_pix, pend_pix, disp_pix;
    logic [BW-1:0]   act_bri, pend_bri, disp_bri, bri_sat;
    logic            pend_valid;
    logic            swap, capture;

    logic [PINS-1:0] oe_n, out_n;
    logic            slot_active, lit;

    // Column c of row r sits on pin c below the anode, and on pin c+1 above it.
    function automatic int col_of(input int r, input int p);
        if (p < r)
            return p;
        else if (p > r)
            return p - 1;
        else
            return 0;
    endfunction

    // Slot/row position counters. The wrap back to (0,0) marks the frame edge.
    always_comb begin
        ph_n       = ph_c + PW'(1);
        row_n      = row_c;
        frame_edge = (row_c == '0) && (ph_c == '0);
        if (ph_c == PW'(S - 1)) begin
            ph_n = '0;
            if (row_c == RW'(PINS - 1))
                row_n = '0;
            else
                row_n = row_c + RW'(1);
        end
    end

    // Buffer control. The swap uses the registered pend_valid. Capture needs
    // frame_ready, which is low whenever pend_valid is high, so the two never
    // coincide.
    always_comb begin
        swap     = frame_edge && pend_valid;
        capture  = load && frame_ready;
        bri_sat  = (brightness > BW'(DWELL)) ? BW'(DWELL) : brightness;
        disp_pix = swap ? pend_pix : act_pix;
        disp_bri = swap ? pend_bri : act_bri;
    end

    // Pin pattern for the slot position being presented. On a swap edge this
    // is the first cycle of the new frame, so it reads the incoming buffer.
    always_comb begin
        oe_n        = '0;
        out_n       = '0;
        slot_active = int'(ph_c) >= BLANK;
        lit         = slot_active && ((int'(ph_c) - BLANK) < int'(disp_bri));
        for (int r = 0; r < PINS; r++) begin
            if (row_c == RW'(r)) begin
                for (int p = 0; p < PINS; p++) begin
                    if (p == r) begin
                        oe_n[p]  = slot_active;
                        out_n[p] = slot_active;
                    end else begin
                        oe_n[p]  = lit && disp_pix[r*(PINS-1) + col_of(r, p)];
                    end
                end
            end
        end
    end

    // Position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_c <= '0;
            ph_c  <= '0;
        end else begin
            row_c <= row_n;
            ph_c  <= ph_n;
        end
    end

    // Pending/active buffers and the load handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_pix     <= '0;
            act_bri     <= '0;
            pend_pix    <= '0;
            pend_bri    <= '0;
            pend_valid  <= 1'b0;
            frame_ready <= 1'b1;
        end else if (swap) begin
            act_pix     <= pend_pix;
            act_bri     <= pend_bri;
            pend_valid  <= 1'b0;
            frame_ready <= 1'b1;
        end else if (capture) begin
            pend_pix    <= pixels;
            pend_bri    <= bri_sat;
            pend_valid  <= 1'b1;
            frame_ready <= 1'b0;
        end
    end

    // Registered pin drive, row index and frame marker, all aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_oe      <= '0;
            pin_out     <= '0;
            row         <= '0;
            frame_start <= 1'b0;
        end else begin
            pin_oe      <= oe_n;
            pin_out     <= out_n;
            row         <= row_c;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Directed bench for charlieplex_scanner at PINS=6, DWELL=4, BLANK=1.
module tb_charlieplex_scanner;

    localparam int PINS  = 6;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int NPIX  = 30;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NPIX-1:0] pixels = '0;
    logic [2:0]      brightness = '0;
    logic            load = 1'b0;
    logic            frame_ready;
    logic [5:0]      pin_out, pin_oe;
    logic [2:0]      row;
    logic            frame_start;

    int n_vec = 0;
    int n_bad = 0;

    charlieplex_scanner #(.PINS(PINS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .pixels(pixels), .brightness(brightness),
        .load(load), .frame_ready(frame_ready), .pin_out(pin_out),
        .pin_oe(pin_oe), .row(row), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPIX-1:0]  pix;
        logic [2:0]       bri;
        int               r;
        logic [3:0][5:0]  oe;   // index = ph-1
        logic [3:0][5:0]  out;
    } vec_t;

    function automatic vec_t mk(input logic [NPIX-1:0] p, input logic [2:0] b, input int r,
                                input logic [5:0] o1, input logic [5:0] o2,
                                input logic [5:0] o3, input logic [5:0] o4,
                                input logic [5:0] v);
        vec_t t;
        t.pix = p; t.bri = b; t.r = r;
        t.oe  = {o4, o3, o2, o1};
        t.out = {v, v, v, v};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 100 && !frame_ready; t++) @(negedge clk);
        if (!frame_ready) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: frame_ready stuck at 0");
        end
    endtask

    // Advance past the current cycle to the next frame_start.
    task automatic wait_fs();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_start && t < 80);
        if (!frame_start) begin
            n_vec++; n_bad++;
            $display("FAIL fs_timeout: no frame_start within 80 cycles");
        end
    endtask

    task automatic do_load(input logic [NPIX-1:0] p, input logic [2:0] b);
        wait_ready();
        pixels = p; brightness = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("ready_drop", 32'(frame_ready), 32'd0);
    endtask

    localparam logic [NPIX-1:0] P00   = 30'd1;
    localparam logic [NPIX-1:0] P3233 = (30'd1 << 17) | (30'd1 << 18);
    localparam logic [NPIX-1:0] P54   = 30'd1 << 29;
    localparam logic [NPIX-1:0] P22   = 30'd1 << 12;
    localparam logic [NPIX-1:0] PALL  = 30'h3FFF_FFFF;

    vec_t vecs[9];

    initial begin
        vecs[0] = mk(P00,   3'd4, 0, 6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b000001);
        vecs[1] = mk(P00,   3'd4, 1, 6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010);
        vecs[2] = mk(P3233, 3'd4, 3, 6'b011100, 6'b011100, 6'b011100, 6'b011100, 6'b001000);
        vecs[3] = mk(P00,   3'd2, 0, 6'b000011, 6'b000011, 6'b000001, 6'b000001, 6'b000001);
        vecs[4] = mk(P00,   3'd7, 0, 6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b000001);
        vecs[5] = mk(P00,   3'd0, 0, 6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000001);
        vecs[6] = mk(P54,   3'd3, 5, 6'b110000, 6'b110000, 6'b110000, 6'b100000, 6'b100000);
        vecs[7] = mk(P22,   3'd1, 2, 6'b001100, 6'b000100, 6'b000100, 6'b000100, 6'b000100);
        vecs[8] = mk(PALL,  3'd4, 4, 6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b010000);

        // Reset values and the free-running scan.
        step(3);
        check("rst_oe",    32'(pin_oe),      32'd0);
        check("rst_out",   32'(pin_out),     32'd0);
        check("rst_row",   32'(row),         32'd0);
        check("rst_fs",    32'(frame_start), 32'd0);
        check("rst_ready", 32'(frame_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("first_fs",  32'(frame_start), 32'd1);
        check("first_row", 32'(row),         32'd0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("scan_fs",  32'(frame_start), 32'(k == 30));
            check("scan_row", 32'(row),         32'((k % 30) / 5));
            if (k == 1) check("dark_anode", 32'(pin_oe), 32'h01);
            if (k == 5) check("dark_blank", 32'(pin_oe), 32'h00);
        end

        // Table-driven pixel patterns.
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].pix, vecs[i].bri);
            wait_fs();
            step(vecs[i].r * 5);
            check("vec_row",      32'(row),     32'(vecs[i].r));
            check("vec_blank_oe", 32'(pin_oe),  32'd0);
            check("vec_blank_out",32'(pin_out), 32'd0);
            for (int ph = 1; ph <= DWELL; ph++) begin
                step(1);
                check("vec_oe",  32'(pin_oe),  32'(vecs[i].oe[ph-1]));
                check("vec_out", 32'(pin_out), 32'(vecs[i].out[ph-1]));
            end
        end

        // A second load while the pending buffer is full is dropped.
        do_load(P00, 3'd4);
        pixels = P3233; brightness = 3'd4; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("ignored_ready", 32'(frame_ready), 32'd0);
        wait_fs();
        check("ready_with_fs", 32'(frame_ready), 32'd1);
        step(1);
        check("hs_row0_oe", 32'(pin_oe), 32'h03);
        step(15);
        check("hs_row3_row", 32'(row),    32'd3);
        check("hs_row3_oe",  32'(pin_oe), 32'h08);

        // A load accepted on the wrap cycle is shown one frame later.
        step(13);
        check("wrap_row",   32'(row),         32'd5);
        check("wrap_ready", 32'(frame_ready), 32'd1);
        pixels = P54; brightness = 3'd4; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("wrap_fs",        32'(frame_start), 32'd1);
        check("wrap_captured",  32'(frame_ready), 32'd0);
        step(26);
        check("wrap_old_oe", 32'(pin_oe), 32'h20);
        wait_fs();
        check("wrap_ready2", 32'(frame_ready), 32'd1);
        step(26);
        check("wrap_new_oe", 32'(pin_oe), 32'h30);

        // A load on the wrap cycle while pending is full is dropped.
        do_load(P22, 3'd4);
        step(2);
        check("full_wrap_ready", 32'(frame_ready), 32'd0);
        pixels = P3233; brightness = 3'd4; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("full_wrap_fs", 32'(frame_start), 32'd1);
        step(1);
        check("full_wrap_ready2", 32'(frame_ready), 32'd1);
        step(10);
        check("full_row2_oe", 32'(pin_oe), 32'h0C);
        step(5);
        check("full_row3_oe", 32'(pin_oe), 32'h08);
        wait_fs();
        step(16);
        check("full_row3_oe2", 32'(pin_oe), 32'h08);

        // Asynchronous reset mid-slot blanks at once and clears the display.
        do_load(P3233, 3'd4);
        wait_fs();
        step(17);
        check("pre_rst_oe",  32'(pin_oe),  32'h1C);
        check("pre_rst_out", 32'(pin_out), 32'h08);
        #1 rst = 1'b1;
        #1;
        check("async_oe",    32'(pin_oe),      32'd0);
        check("async_out",   32'(pin_out),     32'd0);
        check("async_row",   32'(row),         32'd0);
        check("async_ready", 32'(frame_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_fs();
        step(16);
        check("post_rst_row",  32'(row),     32'd3);
        check("post_rst_oe",   32'(pin_oe),  32'h08);
        check("post_rst_out",  32'(pin_out), 32'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/charlieplex_scanner.md
# charlieplex_scanner

Parametrised charlieplexed LED matrix driver for the binary clock display path. It scans `PINS` tri-statable pins, giving `PINS*(PINS-1)` pixels. Pixel data is double-buffered through a valid/ready load port, so frames swap cleanly at frame boundaries. Each row slot has a blanking gap against ghosting and PWM brightness control. It takes the pixel map from the time-formatting logic and drives the package pins through explicit output-enable and output-value vectors.

## Interface
- `PINS`, 6: number of charlieplexed pins; must be at least 2.
- `DWELL`, 4: active cycles per row slot; must be at least 1.
- `BLANK`, 1: all-pins-released cycles at the start of each row slot; must be at least 0.
- `BW`, `$clog2(DWELL+1)`: brightness width.
- `RW`, `max(1, $clog2(PINS))`: row index width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pixels`  in  `PINS*(PINS-1)`: bit `r*(PINS-1)+c` is row r, column c; 1 = lit.
- `brightness`  in  BW: lit cycles per slot; values above `DWELL` saturate to `DWELL`.
- `load`  in  1: capture `pixels` and `brightness` into the pending buffer.
- `frame_ready`  out  1: pending buffer empty; `load` is accepted only when this is high.
- `pin_out`  out  PINS: pin drive value; 0 whenever the matching `pin_oe` bit is 0.
- `pin_oe`  out  PINS: 1 = pin driven, 0 = high-Z.
- `row`  out  RW: row shown on the pins this cycle.
- `frame_start`  out  1: one-cycle pulse on the first cycle of row 0.

## Operation
- Slot length is S = `BLANK+DWELL` cycles; frame length is `PINS*S` cycles.
- Counters:
  - Phase counter `ph` runs 0..S-1.
  - Row counter runs 0..PINS-1.
  - Both wrap to (0,0) after (PINS-1, S-1).
- Blank phase, `ph < BLANK`: `pin_oe = 0` and `pin_out = 0`.
- Active phase, `ph ≥ BLANK`:
  - Anode: pin r driven with `oe = 1`, `out = 1`.
  - Column mapping: column c maps to pin p = (c < r) ? c : c+1.
  - Column pin p gets `oe = 1`, `out = 0` only if pixel(r,c) is set and `(ph-BLANK) < bright_act`; otherwise it is high-Z.
  - `bright_act = 0` still drives the anode but no cathodes.
- Buffers: active buffer (pixels plus `bright_act`) and pending buffer (pixels, brightness, `pend_valid`).
- Load handshake:
  - `load && frame_ready` captures inputs into pending.
  - On the next cycle, `frame_ready` goes to 0.
  - `load` while `frame_ready = 0` is ignored; there is no error flag.
- Frame swap: on the wrap edge, if `pend_valid`, active ← pending, `pend_valid` ← 0, and `frame_ready` ← 1.
- The `pend_valid` value used at the wrap edge is the registered value. Consequences:
  - A load accepted on the wrap cycle lands in pending and is swapped at the following wrap.
  - A load presented on the cycle where `frame_ready` is still 0 (the wrap cycle itself, pending full) is ignored.
- Brightness saturation is applied at capture.

## Timing
- All outputs are registered. `pin_out`, `pin_oe`, `row` and `frame_start` are mutually aligned.
- Reset values:
  - `pin_oe = 0`, `pin_out = 0`, `row = 0`, `frame_start = 0`, `frame_ready = 1`.
  - Active buffer and `bright_act` are 0; pending is cleared.
  - Counters are at (0,0).
- Reset asserted mid-frame clears all of the above immediately (asynchronous), with no completion of the current slot.
- First rising edge after reset release presents row 0, ph 0, with `frame_start = 1`. `frame_start` then repeats every `PINS*S` cycles.
- Latency from load to visible pixels is one to two frames:
  - New data first appears in the row-0 slot that begins with the `frame_start` following the swap edge.
  - Swap edge → `frame_start` of the new frame: 1 cycle.
- `frame_ready` rises in the same cycle as `frame_start` of the swapped frame.
- There is never overlap between rows: on the cycle where `row` changes, the blank phase (when `BLANK ≥ 1`) has all pins high-Z.
- With `BLANK = 0`, the anode switches directly between rows; this is legal.

## Test plan
Configuration for all scenarios: PINS=6, DWELL=4, BLANK=1 (S=5, frame=30).
1. Reset, then release → `pin_oe = 0` during reset and `frame_ready = 1`. `frame_start` is high on cycle 1 after release, then on cycles 31, 61, …; `row` steps 0..5 every 5 cycles.
2. Load pixel (0,0) with brightness 4 → after swap, row 0 slot shows:
   - Cycle 0: `oe = 000000`.
   - Cycles 1–4: `oe = 000011`, `out = 000001`.
   - All other rows: only the anode driven.
3. Load pixels (3,2) and (3,3) → row 3 active phase shows `oe = 011100`, `out = 001000`.
4. Brightness 2 on pixel (0,0) → cathode (pin 1) enabled for 2 cycles, anode for 4. Brightness 7 behaves identically to brightness 4.
5. Handshake:
   - Load with `frame_ready = 1` → `frame_ready = 0` next cycle.
   - A second load with different data is ignored; the first data is displayed.
   - `frame_ready` returns to 1 with `frame_start`.
   - A load on the wrap cycle appears only after the next wrap.
6. Assert `rst` at row 3, ph 2 with pixels lit → `pin_oe` and `pin_out` are 0 before the next clock edge. Afterwards the display is dark (active buffer cleared) until a new load and swap.
